// File: rtl/mant_mult_seq.sv
// rtl/mant_mult_seq.sv - radix-2^RADIX_BITS iterative shift-add mantissa multiplier
//
// Purpose: exact unsigned MANT_W x MANT_W -> 2*MANT_W product. RADIX_BITS
// multiplier bits are retired per RUN cycle, so a result takes
// N = ceil(MANT_W/RADIX_BITS) cycles.
//
// Ports:
//   in_clk           clock, rising edge
//   in_rst_n         asynchronous active-low reset
//   in_valid         operands present
//   out_ready        block can accept operands (IDLE, or DONE while in_ready)
//   in_multiplicand  mantissa A
//   in_multiplier    mantissa B
//   out_valid        out_product holds a finished result (DONE)
//   in_ready         downstream accepts the result
//   out_product      A*B, registered
//   out_busy         high while in RUN
module mant_mult_seq #(
  parameter int MANT_W     = 53,
  parameter int RADIX_BITS = 4
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  input  logic                  in_valid,
  output logic                  out_ready,
  input  logic [MANT_W-1:0]     in_multiplicand,
  input  logic [MANT_W-1:0]     in_multiplier,
  output logic                  out_valid,
  input  logic                  in_ready,
  output logic [2*MANT_W-1:0]   out_product,
  output logic                  out_busy
);

  localparam int N     = (MANT_W + RADIX_BITS - 1) / RADIX_BITS;
  // Multiplier register is padded to a whole number of digits so the
  // digit select is always in range and padding digits read as zero.
  localparam int BW    = N * RADIX_BITS;
  localparam int PW    = MANT_W + RADIX_BITS;
  localparam int AW    = 2 * MANT_W;
  // Wide enough to hold the shifted partial term without losing bits;
  // only the low AW bits are ever non-zero.
  localparam int TW    = AW + RADIX_BITS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t              state, state_nx;
  logic [MANT_W-1:0]   a_q;
  logic [BW-1:0]       b_q;
  logic [AW-1:0]       acc_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                accept;
  logic                last_digit;
  logic [RADIX_BITS-1:0] digit;
  logic [PW-1:0]       partial;
  logic [31:0]         shamt;
  logic [TW-1:0]       term;

  assign digit      = b_q[RADIX_BITS-1:0];
  assign partial    = {{RADIX_BITS{1'b0}}, a_q} * {{MANT_W{1'b0}}, digit};
  assign shamt      = 32'(cnt_q) * 32'(RADIX_BITS);
  assign term       = TW'(partial) << shamt;
  assign last_digit = (cnt_q == CNT_W'(N - 1));
  assign accept     = in_valid & out_ready;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    out_ready = 1'b0;
    out_valid = 1'b0;
    out_busy  = 1'b0;
    case (state)
      S_IDLE: begin
        out_ready = 1'b1;
        if (in_valid) state_nx = S_RUN;
      end
      S_RUN: begin
        out_busy = 1'b1;
        if (last_digit) state_nx = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        // Result hand-off and next accept may share one edge.
        out_ready = in_ready;
        if (in_ready) state_nx = in_valid ? S_RUN : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      a_q   <= in_multiplicand;
      b_q   <= BW'(in_multiplier);
      acc_q <= '0;
      cnt_q <= '0;
    end else if (state == S_RUN) begin
      acc_q <= acc_q + term[AW-1:0];
      b_q   <= b_q >> RADIX_BITS;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_product = acc_q;

endmodule
